// File: rtl/instr_fetch32.sv
// Instruction fetch unit: two-cycle FETCH/EXEC sequencer with
// branch/jump/JR next-PC selection and a sticky misalignment halt.
module instr_fetch32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        opcplus4,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        read_data_1,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  input  logic               stall,
  output logic               fault,
  output logic [31:0]        retired
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] jump_tgt;
  logic        taken;

  assign imem_addr = pc[IMEM_AW+1:2];
  assign opcplus4  = pc + 32'd4;
  assign jump_tgt  = {opcplus4[31:28], Instruction[25:0], 2'b00};
  assign taken     = (Branch & Zero) | (nBranch & ~Zero);

  // Jr outranks the absolute jumps, which outrank a taken branch
  always_comb begin
    next_pc = opcplus4;
    if (Jr)
      next_pc = read_data_1;
    else if (Jmp || Jal)
      next_pc = jump_tgt;
    else if (taken)
      next_pc = Addr_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      Instruction <= 32'd0;
      retired     <= 32'd0;
      fault       <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          Instruction <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= HALT;
            end else begin
              pc      <= next_pc;
              retired <= retired + 32'd1;
              state   <= FETCH;
            end
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= FETCH;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch32.sv
// Randomized self-checking bench for instr_fetch32 with a
// word-array ROM and an instruction-level next-PC model.
module tb_instr_fetch32;

  localparam int          AW     = 14;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic [31:0]   Instruction;
  logic          instr_valid;
  logic [31:0]   pc;
  logic [31:0]   opcplus4;
  logic [31:0]   Addr_result = 32'd0;
  logic [31:0]   read_data_1 = 32'd0;
  logic          Branch = 1'b0;
  logic          nBranch = 1'b0;
  logic          Jmp = 1'b0;
  logic          Jal = 1'b0;
  logic          Jr = 1'b0;
  logic          Zero = 1'b0;
  logic          stall = 1'b0;
  logic          fault;
  logic [31:0]   retired;

  logic [31:0] rom [0:(1<<AW)-1];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  int          checks = 0;
  int          errors = 0;

  instr_fetch32 #(.RESET_PC(RST_PC), .IMEM_AW(AW)) dut (
    .clock(clock),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .Instruction(Instruction),
    .instr_valid(instr_valid),
    .pc(pc),
    .opcplus4(opcplus4),
    .Addr_result(Addr_result),
    .read_data_1(read_data_1),
    .Branch(Branch),
    .nBranch(nBranch),
    .Jmp(Jmp),
    .Jal(Jal),
    .Jr(Jr),
    .Zero(Zero),
    .stall(stall),
    .fault(fault),
    .retired(retired)
  );

  always #5 clock = ~clock;

  // ROM latches mid-cycle so data for the FETCH address is ready at capture
  always @(negedge clock) imem_rdata <= rom[imem_addr];

  function automatic logic [31:0] rom_at(input logic [31:0] byte_addr);
    return rom[(byte_addr / 4) % (1 << AW)];
  endfunction

  function automatic logic [31:0] ref_next(
    input logic [31:0] p, ins,
    input bit jr, jj, jl, br, nb, z,
    input logic [31:0] ar, rd
  );
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (jr) return rd;
    if (jj || jl)
      return (p4 & 32'hF000_0000) + ((ins % (32'd1 << 26)) * 4);
    if ((br && z) || (nb && !z)) return ar;
    return p4;
  endfunction

  task automatic clr_ctl();
    Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
    stall = 0; Addr_result = 0; read_data_1 = 0;
  endtask

  task automatic rand_ctl();
    Branch = 1'($urandom); nBranch = 1'($urandom);
    Jmp = 1'($urandom); Jal = 1'($urandom);
    Jr = 1'($urandom); Zero = 1'($urandom);
    Addr_result = $urandom; read_data_1 = $urandom;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    clr_ctl();
    m_pc  = RST_PC;
    m_ret = 0;
  endtask

  // From a FETCH negedge: Jr to tgt, arriving at the next FETCH negedge
  task automatic jr_to(input logic [31:0] tgt);
    @(negedge clock);
    Jr = 1; read_data_1 = tgt;
    @(negedge clock);
    clr_ctl();
    m_pc = tgt;
    m_ret = m_ret + 1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; Jmp = 1; Jr = 1; read_data_1 = 32'h40;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (pc !== RST_PC) begin
      errors++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid);
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("FAIL rst_retired got=%0d exp=0", retired);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL rst_fault got=%b exp=0", fault);
    end
    checks++;
    if (Instruction !== 32'd0) begin
      errors++; $display("FAIL rst_instr got=%h exp=0", Instruction);
    end
    checks++;
    if (imem_addr !== AW'(RST_PC / 4)) begin
      errors++; $display("FAIL rst_addr got=%h", imem_addr);
    end
    reset = 0;
    clr_ctl();
    m_pc = RST_PC;
    m_ret = 0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++)
      rom[i] = ($urandom & 32'hFFFF_FF00) | i;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      logic        ev;
      logic [31:0] ep;
      @(negedge clock);
      ev = (cyc % 2 == 0);
      ep = ev ? 32'(4 * (cyc / 2)) : 32'(4 * (cyc / 2 + 1));
      checks++;
      if (instr_valid !== ev || pc !== ep) begin
        errors++;
        $display("FAIL seq_cyc%0d valid=%b pc=%h exp valid=%b pc=%h",
                 cyc, instr_valid, pc, ev, ep);
      end
      checks++;
      if (retired !== 32'((cyc + 1) / 2)) begin
        errors++;
        $display("FAIL seq_retired cyc%0d got=%0d exp=%0d",
                 cyc, retired, (cyc + 1) / 2);
      end
      if (ev) begin
        checks++;
        if (Instruction !== rom[cyc/2]) begin
          errors++;
          $display("FAIL seq_instr got=%h exp=%h", Instruction, rom[cyc/2]);
        end
      end
    end
    m_pc = 32'h10;
    m_ret = 4;
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ar, exp;
      bit br, z;
      br = (k < 2);
      z  = (k % 2 == 0);
      ar = k == 0 ? 32'h40 : ($urandom & 32'h0000_FFFC);
      jr_to(32'h10);
      @(negedge clock);
      checks++;
      if (pc !== 32'h10 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL br_at10 pc=%h valid=%b exp pc=10 valid=1",
                 pc, instr_valid);
      end
      Branch = br; nBranch = !br; Zero = z; Addr_result = ar;
      exp = ref_next(32'h10, Instruction, 0, 0, 0, br, !br, z, ar, 0);
      @(negedge clock);
      clr_ctl();
      m_pc = exp;
      m_ret = m_ret + 1;
      checks++;
      if (pc !== exp || retired !== m_ret) begin
        errors++;
        $display("FAIL br_case%0d pc=%h ret=%0d exp pc=%h ret=%0d",
                 k, pc, retired, exp, m_ret);
      end
    end
  endtask

  task automatic test_jump();
    rom[8] = ($urandom & 32'hFC00_0000) | 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] rd, exp;
      rd = $urandom & 32'hFFFF_FFFC;
      jr_to(32'h20);
      @(negedge clock);
      checks++;
      if (opcplus4 !== 32'h24 || Instruction !== rom[8]) begin
        errors++;
        $display("FAIL jmp_exec p4=%h ins=%h exp p4=24 ins=%h",
                 opcplus4, Instruction, rom[8]);
      end
      Jmp = (k == 0); Jal = (k != 0); Jr = (k == 2); read_data_1 = rd;
      exp = (k == 2) ? rd : 32'h0000_0400;
      @(negedge clock);
      clr_ctl();
      m_pc = exp;
      m_ret = m_ret + 1;
      checks++;
      if (pc !== exp) begin
        errors++;
        $display("FAIL jmp_case%0d pc=%h exp=%h", k, pc, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ins0, pc0, ret0;
    @(negedge clock);
    ins0 = rom_at(m_pc);
    pc0  = m_pc;
    ret0 = m_ret;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_ctl();
      @(negedge clock);
      checks++;
      if (Instruction !== ins0 || pc !== pc0 || retired !== ret0 ||
          instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d ins=%h pc=%h ret=%0d v=%b exp %h %h %0d 1",
                 k, Instruction, pc, retired, instr_valid, ins0, pc0, ret0);
      end
    end
    clr_ctl();
    @(negedge clock);
    m_pc = pc0 + 4;
    m_ret = ret0 + 1;
    checks++;
    if (pc !== m_pc || retired !== m_ret || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release pc=%h ret=%0d v=%b exp %h %0d 0",
               pc, retired, instr_valid, m_pc, m_ret);
    end
  endtask

  task automatic test_wrap();
    jr_to(32'hFFFF_FFFC);
    @(negedge clock);
    checks++;
    if (opcplus4 !== 32'd0 || imem_addr !== {AW{1'b1}} ||
        Instruction !== rom[(1<<AW)-1]) begin
      errors++;
      $display("FAIL wrap p4=%h addr=%h ins=%h exp 0 %h %h",
               opcplus4, imem_addr, Instruction, {AW{1'b1}}, rom[(1<<AW)-1]);
    end
    @(negedge clock);
    m_pc = 0;
    m_ret = m_ret + 1;
    checks++;
    if (pc !== 32'd0) begin
      errors++; $display("FAIL wrap_pc got=%h exp=0", pc);
    end
  endtask

  task automatic test_fault();
    logic [31:0] pc0, ret0;
    @(negedge clock);
    pc0 = m_pc;
    ret0 = m_ret;
    Jr = 1; Jal = 1; read_data_1 = 32'h0000_0102;
    @(negedge clock);
    clr_ctl();
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || pc !== pc0 ||
        retired !== ret0) begin
      errors++;
      $display("FAIL fault_enter f=%b v=%b pc=%h ret=%0d exp 1 0 %h %0d",
               fault, instr_valid, pc, retired, pc0, ret0);
    end
    for (int k = 0; k < 4; k++) begin
      rand_ctl();
      stall = 1'($urandom);
      @(negedge clock);
    end
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || pc !== pc0 ||
        retired !== ret0) begin
      errors++;
      $display("FAIL fault_frozen f=%b v=%b pc=%h ret=%0d exp 1 0 %h %0d",
               fault, instr_valid, pc, retired, pc0, ret0);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if (fault !== 1'b0 || pc !== RST_PC) begin
      errors++;
      $display("FAIL fault_clear f=%b pc=%h exp 0 %h", fault, pc, RST_PC);
    end
    reset = 0;
    clr_ctl();
    m_pc = RST_PC;
    m_ret = 0;
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    stall = 1; Jmp = 1; reset = 1;
    @(negedge clock);
    checks++;
    if (pc !== RST_PC || retired !== 32'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid pc=%h ret=%0d v=%b exp %h 0 0",
               pc, retired, instr_valid, RST_PC);
    end
    reset = 0;
    clr_ctl();
    m_pc = RST_PC;
    m_ret = 0;
    @(negedge clock);
    checks++;
    if (instr_valid !== 1'b1 || pc !== RST_PC ||
        Instruction !== rom_at(RST_PC)) begin
      errors++;
      $display("FAIL rst_mid_first v=%b pc=%h ins=%h exp 1 %h %h",
               instr_valid, pc, Instruction, RST_PC, rom_at(RST_PC));
    end
    @(negedge clock);
    m_pc = RST_PC + 4;
    m_ret = 1;
  endtask

  task automatic test_random();
    bit halted;
    halted = 0;
    for (int n = 0; n < 60 && !halted; n++) begin
      logic [31:0] exp;
      int nst;
      @(negedge clock);
      checks++;
      if (pc !== m_pc || instr_valid !== 1'b1 || retired !== m_ret ||
          Instruction !== rom_at(m_pc)) begin
        errors++;
        $display("FAIL rnd_exec%0d pc=%h v=%b ret=%0d ins=%h exp %h 1 %0d %h",
                 n, pc, instr_valid, retired, Instruction,
                 m_pc, m_ret, rom_at(m_pc));
      end
      nst = $urandom_range(0, 2);
      for (int s = 0; s < nst; s++) begin
        stall = 1;
        rand_ctl();
        @(negedge clock);
      end
      stall = 0;
      rand_ctl();
      Jr  = ($urandom_range(0, 3) == 0);
      Jmp = ($urandom_range(0, 4) == 0);
      Jal = ($urandom_range(0, 4) == 0);
      Addr_result = Addr_result & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) != 0)
        read_data_1 = read_data_1 & 32'hFFFF_FFFC;
      exp = ref_next(m_pc, rom_at(m_pc), Jr, Jmp, Jal, Branch, nBranch,
                     Zero, Addr_result, read_data_1);
      @(negedge clock);
      clr_ctl();
      if (exp % 4 != 0) begin
        halted = 1;
        checks++;
        if (fault !== 1'b1 || pc !== m_pc || retired !== m_ret) begin
          errors++;
          $display("FAIL rnd_fault f=%b pc=%h ret=%0d exp 1 %h %0d",
                   fault, pc, retired, m_pc, m_ret);
        end
      end else begin
        m_pc = exp;
        m_ret = m_ret + 1;
        checks++;
        if (pc !== m_pc || fault !== 1'b0 || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_next%0d pc=%h f=%b v=%b exp %h 0 0",
                   n, pc, fault, instr_valid, m_pc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    clr_ctl();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_fault();
    test_reset_mid_exec();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      test_random();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
